// File: rtl/uart_rx.sv
// UART receiver: synchronised start detection, mid-bit sampling, even parity and stop checks,
// one-entry valid/ready output buffer with sticky parity/framing/overrun flags.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o,
  input  logic        err_clr_i
);

  // state          | meaning
  // IDLE           | waiting for a falling edge on the synchronised line
  // START_BIT      | confirming the start bit at half period
  // DATA           | sampling data bits LSB first
  // PARITY         | sampling the even parity bit
  // STOP_BIT_FIRST | sampling the first stop bit
  // STOP_BIT_LAST  | sampling the second stop bit
  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA, PARITY, STOP_BIT_FIRST, STOP_BIT_LAST
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        rs, rs_prev_q, fall;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_last;
  logic        par_acc_q, par_acc_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        done_q, done_d;
  logic        tick;
  logic        accept;

  assign rs       = sync_q[SYNC_STAGES-1];
  assign fall     = rs_prev_q & ~rs;
  assign tick     = (cnt_q == cfg_div_i);
  assign bit_last = {1'b1, cfg_bits_i};
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q    <= '1;
      rs_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rs_prev_q <= rs;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      par_acc_q <= 1'b0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      par_acc_q <= par_acc_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    par_acc_d = par_acc_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START_BIT;
      end
      START_BIT: begin
        if (cnt_q == (cfg_div_i >> 1)) begin
          cnt_d = '0;
          if (rs) begin
            state_d = IDLE;
          end else begin
            // shift register cleared so bits above the data width read as zero
            state_d   = DATA;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            shreg_d   = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d              = '0;
          shreg_d[bit_cnt_q] = rs;
          par_acc_d          = par_acc_q ^ rs;
          if (bit_cnt_q == bit_last)
            state_d = cfg_parity_en_i ? PARITY : STOP_BIT_FIRST;
          else
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = STOP_BIT_FIRST;
          if (rs != par_acc_q) perr_d = 1'b1;
        end
      end
      STOP_BIT_FIRST: begin
        if (tick) begin
          cnt_d = '0;
          if (!rs) ferr_d = 1'b1;
          if (cfg_stop_bits_i) begin
            state_d = STOP_BIT_LAST;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STOP_BIT_LAST: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (!rs) ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign accept = ~rx_valid_o | rx_ready_i;

  // Output buffer and sticky flags; a new error in the clear cycle survives.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      if (done_q && accept) begin
        rx_data_o  <= shreg_q;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      err_parity_o  <= (err_parity_o  & ~err_clr_i) | (done_q & accept & perr_q);
      err_frame_o   <= (err_frame_o   & ~err_clr_i) | (done_q & accept & ferr_q);
      err_overrun_o <= (err_overrun_o & ~err_clr_i) | (done_q & ~accept);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serialiser drives frames, a frame-level model predicts the
// completion cycle of each character and the buffer/flag state, checked every cycle.
module tb_uart_rx;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        busy_o;
  logic        cfg_en_i = 1'b0;
  logic [15:0] cfg_div_i = 16'd15;
  logic        cfg_parity_en_i = 1'b0;
  logic [1:0]  cfg_bits_i = 2'b11;
  logic        cfg_stop_bits_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        err_parity_o, err_frame_o, err_overrun_o;
  logic        err_clr_i = 1'b0;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_i(rx_i), .busy_o(busy_o),
    .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_bits_i(cfg_bits_i), .cfg_stop_bits_i(cfg_stop_bits_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .err_parity_o(err_parity_o), .err_frame_o(err_frame_o), .err_overrun_o(err_overrun_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] data; bit perr; bit ferr; } comp_t;
  typedef struct { int lo; int hi; } win_t;
  comp_t comp_q[$];
  win_t  win_q[$];

  bit         m_valid = 0, m_perr = 0, m_ferr = 0, m_ovr = 0;
  logic [7:0] m_data = 8'h00;
  bit         ready_prev = 0, clr_prev = 0;
  bit         chk_en = 0, busy_seen = 0;

  int ready_mode = 0;
  int ready_at = -1;
  bit ready_req = 0, clr_req = 0, rand_clr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // consumer / error-clear driver
  initial begin
    forever begin
      @(posedge clk_i); #1;
      rx_ready_i = ready_req || (cyc + 1 == ready_at) || (ready_mode == 1) ||
                   (ready_mode == 2 && $urandom_range(0, 1) == 1);
      ready_req  = 0;
      err_clr_i  = clr_req || (rand_clr && $urandom_range(0, 15) == 0);
      clr_req    = 0;
    end
  end

  // frame-level model and per-cycle compare
  always @(negedge clk_i) begin : cmp
    bit    old_v, s_p, s_f, s_o, busy_exp;
    comp_t c;
    if (chk_en) begin
      s_p = 0; s_f = 0; s_o = 0;
      old_v = m_valid;
      if (comp_q.size() > 0 && comp_q[0].cyc == cyc) begin
        c = comp_q.pop_front();
        if (!old_v || ready_prev) begin
          m_valid = 1; m_data = c.data; s_p = c.perr; s_f = c.ferr;
        end else begin
          s_o = 1;
        end
      end else if (old_v && ready_prev) begin
        m_valid = 0;
      end
      if (clr_prev) begin m_perr = 0; m_ferr = 0; m_ovr = 0; end
      m_perr |= s_p; m_ferr |= s_f; m_ovr |= s_o;
      while (win_q.size() > 0 && win_q[0].hi < cyc) void'(win_q.pop_front());
      busy_exp = (win_q.size() > 0) && (win_q[0].lo <= cyc) && (cyc <= win_q[0].hi);
      chk("valid", 32'(rx_valid_o), 32'(m_valid));
      if (m_valid) chk("data", 32'(rx_data_o), 32'(m_data));
      chk("err_parity", 32'(err_parity_o), 32'(m_perr));
      chk("err_frame", 32'(err_frame_o), 32'(m_ferr));
      chk("err_overrun", 32'(err_overrun_o), 32'(m_ovr));
      chk("busy", 32'(busy_o), 32'(busy_exp));
      if (busy_o) busy_seen = 1;
    end
    ready_prev = rx_ready_i;
    clr_prev   = err_clr_i;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic consume_and_clear();
    ready_req = 1; clr_req = 1;
    idle(3);
  endtask

  // Serialise one frame with the current configuration; optionally corrupt parity/stop,
  // leave the line low afterwards, drop the enable at a data bit, or assert ready on completion.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_s1,
                            input bit bad_s2, input bit hold_low, input int abort_bit,
                            input bit ready_on_done);
    int nd, p, h, m, k;
    logic [8:0] mask;
    logic [7:0] dm;
    logic bits[$];
    comp_t c;
    win_t w;
    nd   = 5 + int'(cfg_bits_i);
    p    = int'(cfg_div_i) + 1;
    h    = int'(cfg_div_i >> 1);
    mask = (9'd1 << nd) - 9'd1;
    dm   = d & mask[7:0];
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(dm[i]);
    if (cfg_parity_en_i) bits.push_back((^dm) ^ bad_par);
    bits.push_back(!bad_s1);
    if (cfg_stop_bits_i) bits.push_back(!bad_s2);
    m = bits.size() - 1;
    @(posedge clk_i); #1;
    k = cyc;
    if (abort_bit < 0) begin
      c.cyc  = k + 5 + h + m * p;
      c.data = dm;
      c.perr = bad_par && cfg_parity_en_i;
      c.ferr = bad_s1 || (cfg_stop_bits_i && bad_s2);
      comp_q.push_back(c);
      w.lo = k + 3; w.hi = k + 3 + h + m * p;
      if (ready_on_done) ready_at = c.cyc;
    end else begin
      w.lo = k + 3; w.hi = k + p * (1 + abort_bit);
    end
    win_q.push_back(w);
    for (int j = 0; j < bits.size(); j++) begin
      rx_i = bits[j];
      if (abort_bit >= 0 && j == abort_bit + 1) cfg_en_i = 0;
      for (int t = 0; t < p; t++) begin
        @(posedge clk_i); #1;
        if (abort_bit >= 0 && j == abort_bit + 1 && t == 0) chk("abort_busy", 32'(busy_o), 32'd0);
      end
    end
    if (!hold_low) rx_i = 1'b1;
    if (abort_bit >= 0) begin
      idle(p);
      cfg_en_i = 1;
    end
  endtask

  task automatic set_cfg(input int div, input logic [1:0] b, input bit par, input bit st);
    cfg_div_i = 16'(div); cfg_bits_i = b; cfg_parity_en_i = par; cfg_stop_bits_i = st;
  endtask

  initial begin
    int k;
    win_t w;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_data", 32'(rx_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_errs", 32'({err_parity_o, err_frame_o, err_overrun_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1; cfg_en_i = 1; chk_en = 1;
    idle(5);

    // 8N1 0xA5, held until consumed
    set_cfg(15, 2'b11, 0, 0);
    send_frame(8'hA5, 0, 0, 0, 0, -1, 0);
    idle(30);
    chk("a5_data", 32'(rx_data_o), 32'hA5);
    chk("a5_valid", 32'(rx_valid_o), 32'd1);
    chk("a5_errs", 32'({err_parity_o, err_frame_o, err_overrun_o}), 32'd0);
    idle(40);
    chk("a5_hold", 32'({rx_valid_o, rx_data_o}), 32'h1A5);
    ready_req = 1; idle(3);
    chk("a5_consumed", 32'(rx_valid_o), 32'd0);

    // 7E1 0x55 with wrong parity bit
    set_cfg(15, 2'b10, 1, 0);
    send_frame(8'h55, 1, 0, 0, 0, -1, 0);
    idle(30);
    chk("par_data", 32'(rx_data_o), 32'h55);
    chk("par_err", 32'(err_parity_o), 32'd1);
    clr_req = 1; idle(3);
    chk("par_clr", 32'(err_parity_o), 32'd0);
    ready_req = 1; idle(3);

    // 4-cycle low glitch: false start
    set_cfg(15, 2'b11, 0, 0);
    @(posedge clk_i); #1;
    k = cyc; w.lo = k + 3; w.hi = k + 3 + 7; win_q.push_back(w);
    busy_seen = 0;
    rx_i = 0; idle(4); rx_i = 1;
    idle(30);
    chk("glitch_valid", 32'(rx_valid_o), 32'd0);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_busy", 32'(busy_o), 32'd0);

    // back-to-back with no consumer -> overrun
    send_frame(8'h11, 0, 0, 0, 0, -1, 0);
    send_frame(8'h22, 0, 0, 0, 0, -1, 0);
    idle(30);
    chk("ovr_data", 32'(rx_data_o), 32'h11);
    chk("ovr_flag", 32'(err_overrun_o), 32'd1);
    consume_and_clear();
    send_frame(8'h33, 0, 0, 0, 0, -1, 0);
    send_frame(8'h44, 0, 0, 0, 0, -1, 1);
    idle(30);
    chk("rdy_data", 32'(rx_data_o), 32'h44);
    chk("rdy_valid", 32'(rx_valid_o), 32'd1);
    chk("rdy_no_ovr", 32'(err_overrun_o), 32'd0);
    consume_and_clear();

    // 8N2, second stop low, line then held low
    set_cfg(15, 2'b11, 0, 1);
    send_frame(8'h3C, 0, 0, 1, 1, -1, 0);
    idle(80);
    chk("frm_data", 32'(rx_data_o), 32'h3C);
    chk("frm_err", 32'(err_frame_o), 32'd1);
    chk("frm_low_busy", 32'(busy_o), 32'd0);
    rx_i = 1; idle(20);
    consume_and_clear();

    // loopback-style sweep at P=8 over every format, random consumer
    ready_mode = 2;
    for (int b = 0; b < 4; b++)
      for (int pe = 0; pe < 2; pe++)
        for (int st = 0; st < 2; st++) begin
          set_cfg(7, 2'(b), pe[0], st[0]);
          repeat (2) begin
            send_frame(8'($urandom), 0, 0, 0, 0, -1, 0);
            idle($urandom_range(0, 8));
          end
          idle(16);
        end
    set_cfg(7, 2'b11, 1, 1);
    send_frame(8'h5A, 0, 0, 0, 0, 2, 0);
    idle(20);

    // randomized formats, dividers, error injection and clears
    rand_clr = 1;
    for (int n = 0; n < 40; n++) begin
      set_cfg($urandom_range(3, 12), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1);
      send_frame(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, 0, -1, 0);
      idle(int'(cfg_div_i) + 8 + $urandom_range(0, 20));
    end
    rand_clr = 0;
    ready_mode = 0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that pairs with the team's uart_tx and uses the same configuration encoding.
- Synchronises the serial input and detects start bits.
- Samples each bit at mid-period.
- Checks even parity and the stop bit(s).
- Presents each received character on a one-entry valid/ready output buffer, with sticky parity, framing and overrun error flags.
- Sits between the pad and the UART RX FIFO or register block.

Parameters:
SYNC_STAGES, 2, number of input synchroniser flops (minimum 2).

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset, asynchronous, active-low
rx_i  input  1  serial input, asynchronous to clk_i, idle high
busy_o  output  1  high while a frame is in progress (FSM not IDLE)
cfg_en_i  input  1  receiver enable
cfg_div_i  input  16  bit period minus one; P = cfg_div_i+1 clk cycles
cfg_parity_en_i  input  1  1 = even parity bit present after the data bits
cfg_bits_i  input  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits
rx_data_o  output  8  received character; unused upper bits are 0
rx_valid_o  output  1  rx_data_o holds an unconsumed character
rx_ready_i  input  1  consumer accepts the character
err_parity_o  output  1  sticky: parity mismatch
err_frame_o  output  1  sticky: a stop bit was sampled low
err_overrun_o  output  1  sticky: a character was completed while the buffer was full
err_clr_i  input  1  clears all three error flags

Behaviour:
Reset:
- Synchroniser flops reset to 1.
- FSM resets to IDLE; busy_o=0.
- rx_data_o=0, rx_valid_o=0, all error flags 0.

Synchronisation and start detection:
- rx_i passes through SYNC_STAGES flops; rs denotes the synchronised value.
- A start is a falling edge of rs (previous rs=1, current rs=0).
- A line held low does not retrigger a start.

FSM states: IDLE, START_BIT, DATA, PARITY, STOP_BIT_FIRST, STOP_BIT_LAST.
- IDLE: on a falling edge with cfg_en_i=1, clear the baud counter and go to START_BIT.
- START_BIT: sample when the counter reaches cfg_div_i>>1 (half period).
  - rs=1: false start; return to IDLE with no data and no error.
  - rs=0: clear the counter and go to DATA with bit_cnt=0 and parity accumulator=0.
- All later samples are taken when the counter equals cfg_div_i (every P cycles, i.e. mid-bit). The counter then wraps to 0.
- DATA: at each sample, write rs to shift-register bit index bit_cnt (LSB first) and XOR it into the parity accumulator.
  - When bit_cnt equals the target (4/5/6/7 for cfg_bits_i 00/01/10/11), go to PARITY if cfg_parity_en_i=1, else STOP_BIT_FIRST.
  - Otherwise increment bit_cnt.
- PARITY: sample; if rs does not equal the accumulator, set the frame's parity-error flag. Go to STOP_BIT_FIRST.
- STOP_BIT_FIRST: sample; rs=0 marks a framing error.
  - cfg_stop_bits_i=1: go to STOP_BIT_LAST.
  - Otherwise complete the frame and go to IDLE.
- STOP_BIT_LAST: sample; rs=0 marks a framing error. Complete the frame and go to IDLE.
- Configuration inputs are sampled live; software changes them only while busy_o=0.

Frame completion (the cycle after the final stop sample):
- If rx_valid_o=0, or rx_ready_i=1 in the same cycle:
  - Load rx_data_o with the masked shift register (bits above the data width = 0).
  - Set rx_valid_o=1.
  - OR the frame's parity and framing errors into the sticky flags.
- Otherwise:
  - Discard the frame.
  - Set err_overrun_o.
  - Leave rx_data_o unchanged.
- Characters with parity or framing errors are still delivered.

Handshake:
- A character is consumed on a cycle where rx_valid_o and rx_ready_i are both 1.
- rx_valid_o drops the next cycle unless a new frame completes in that same cycle, in which case it stays 1 with the new data.
- rx_data_o is stable while rx_valid_o=1.

Error flags:
- err_clr_i clears all flags.
- If err_clr_i coincides with a new error, the set wins.

Disable:
- cfg_en_i=0 forces the FSM to IDLE and clears the baud counter; a frame in progress is aborted with nothing delivered.
- The output buffer and error flags are retained.

Edge case:
- With cfg_div_i=0 (P=1) the block is not required to operate. Minimum supported cfg_div_i is 3.

Test Plan:
- cfg_div_i=15, 8N1, drive 0xA5 LSB first at P=16 -> rx_data_o=0xA5, rx_valid_o=1, held until rx_ready_i; no error flags.
- cfg_bits_i=10, parity on, drive 0x55 with parity bit 1 (correct is 0) -> rx_data_o=0x55, err_parity_o=1; err_clr_i pulse -> 0.
- Low glitch on rx_i for 4 cycles (less than P/2=8), cfg_div_i=15 -> false start; no rx_valid_o, FSM back to IDLE, busy_o pulses only.
- Two back-to-back 8N1 frames 0x11, 0x22 with rx_ready_i=0 -> rx_data_o stays 0x11, err_overrun_o=1; with rx_ready_i asserted in the completion cycle of 0x22 -> 0x22 delivered, no overrun.
- 8N2, second stop bit driven low, data 0x3C -> rx_data_o=0x3C, err_frame_o=1; line then held low -> no new frame until rs rises and falls again.
- Loopback with uart_tx, cfg_div_i=7, 5-bit/parity/2-stop and all cfg_bits_i values, random data -> every character received equals the transmitted data masked to width; no errors; cfg_en_i dropped mid-frame -> frame aborted, busy_o=0 next cycle.
